// File: rtl/filter_read_addr_gen_if.sv
// filter_read_addr_gen_if
// Read-address bus between the filter read sequencer and the scratchpad
// read port.
//   addr_valid   : read_pointer carries a live address this cycle
//   addr_ready   : consumer accepts read_pointer this cycle
//   read_pointer : scratchpad read address
//   co_filter    : current word is the last of its row
//   filter_end   : current word is the last of the whole filter
//   last_filter  : the filter being walked is the final one
// Modports: master = sequencer side, slave = scratchpad/consumer side.
interface filter_read_addr_gen_if #(
  parameter int ADDR_W = 4
) ();
  logic              addr_valid;
  logic              addr_ready;
  logic [ADDR_W-1:0] read_pointer;
  logic              co_filter;
  logic              filter_end;
  logic              last_filter;

  modport master (
    output addr_valid,
    output read_pointer,
    output co_filter,
    output filter_end,
    output last_filter,
    input  addr_ready
  );

  modport slave (
    input  addr_valid,
    input  read_pointer,
    input  co_filter,
    input  filter_end,
    input  last_filter,
    output addr_ready
  );
endinterface

// File: rtl/filter_read_addr_gen.sv
// filter_read_addr_gen
// Walks a set of multi-channel filters stored back-to-back in a circular
// scratchpad, one read pointer per cycle under valid/ready, and moves to the
// next filter only when the datapath asks for it with next_filter.
// Ports:
//   clk, rst          : clock, synchronous active-low reset
//   cfg_filter_size   : words per row (per channel)
//   cfg_num_ch        : channels per filter
//   cfg_num_filters   : number of filters to walk
//   cfg_base          : address of word 0 of filter 0
//   cfg_repeat        : wrap back to filter 0 instead of finishing
//   start             : latch configuration and begin (IDLE only)
//   next_filter       : advance to the next filter (WAIT only)
//   busy, done        : activity flag, one-cycle completion pulse
//   cfg_err           : one-cycle pulse when a start is rejected
//   rd                : read-address bus (master side)
module filter_read_addr_gen #(
  parameter int SP_DEPTH = 16,
  parameter int ADDR_W   = $clog2(SP_DEPTH),
  parameter int SIZE_W   = 8,
  parameter int CH_W     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [SIZE_W-1:0]     cfg_filter_size,
  input  logic [CH_W-1:0]       cfg_num_ch,
  input  logic [SIZE_W-1:0]     cfg_num_filters,
  input  logic [ADDR_W-1:0]     cfg_base,
  input  logic                  cfg_repeat,
  input  logic                  start,
  input  logic                  next_filter,
  output logic                  busy,
  output logic                  done,
  output logic                  cfg_err,
  filter_read_addr_gen_if.master rd
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam int STRIDE_FULL_W = SIZE_W + CH_W;
  localparam int TOTAL_W       = STRIDE_FULL_W + SIZE_W;

  localparam logic [ADDR_W:0]    DEPTH       = (ADDR_W+1)'(SP_DEPTH);
  localparam logic [TOTAL_W-1:0] DEPTH_TOTAL = TOTAL_W'(SP_DEPTH);

  logic [1:0]        state;
  logic [SIZE_W-1:0] fs_q;
  logic [CH_W-1:0]   nch_q;
  logic [SIZE_W-1:0] nf_q;
  logic [ADDR_W-1:0] base_q;
  logic              repeat_q;
  logic [ADDR_W:0]   stride_q;
  logic [ADDR_W-1:0] filter_base;
  logic [ADDR_W-1:0] addr;
  logic [SIZE_W-1:0] point;
  logic [CH_W-1:0]   ch;
  logic [SIZE_W-1:0] filt;
  logic              cfg_err_q;

  logic [STRIDE_FULL_W-1:0] stride_full;
  logic [TOTAL_W-1:0]       total_words;
  logic                     cfg_bad;
  logic                     last_point;
  logic                     last_ch;
  logic                     in_run;
  logic                     fend;

  // Circular add: both operands are below/at the depth, so one conditional
  // subtraction of the one-bit-wider sum is enough to wrap.
  function automatic logic [ADDR_W-1:0] mod_add(input logic [ADDR_W-1:0] a,
                                                input logic [ADDR_W:0]   b);
    logic [ADDR_W:0] sum;
    sum = {1'b0, a} + b;
    if (sum >= DEPTH) sum = sum - DEPTH;
    return sum[ADDR_W-1:0];
  endfunction

  // Start-time validation. The products are kept full width so an oversized
  // configuration cannot alias into a small-looking stride; only the start
  // path uses multipliers, the address walk is pure adds.
  assign stride_full = {{CH_W{1'b0}}, cfg_filter_size} * {{SIZE_W{1'b0}}, cfg_num_ch};
  assign total_words = {{SIZE_W{1'b0}}, stride_full} *
                       {{STRIDE_FULL_W{1'b0}}, cfg_num_filters};
  assign cfg_bad = (cfg_filter_size == '0) || (cfg_num_ch == '0) ||
                   (cfg_num_filters == '0) || ({1'b0, cfg_base} >= DEPTH) ||
                   (total_words > DEPTH_TOTAL);

  // Position flags decoded from registered counters.
  assign in_run     = (state == S_RUN);
  assign last_point = (point == fs_q - SIZE_W'(1));
  assign last_ch    = (ch == nch_q - CH_W'(1));
  assign fend       = in_run && last_point && last_ch;

  assign rd.addr_valid   = in_run;
  assign rd.read_pointer = addr;
  assign rd.co_filter    = in_run && last_point;
  assign rd.filter_end   = fend;
  assign rd.last_filter  = ((state == S_RUN) || (state == S_WAIT)) &&
                           (filt == nf_q - SIZE_W'(1));

  assign busy    = (state != S_IDLE);
  assign done    = (state == S_DONE);
  assign cfg_err = cfg_err_q;

  // Main sequencer: configuration latch, address/point/channel walk, filter
  // advance and repeat wrap.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= S_IDLE;
      fs_q        <= '0;
      nch_q       <= '0;
      nf_q        <= '0;
      base_q      <= '0;
      repeat_q    <= 1'b0;
      stride_q    <= '0;
      filter_base <= '0;
      addr        <= '0;
      point       <= '0;
      ch          <= '0;
      filt        <= '0;
      cfg_err_q   <= 1'b0;
    end else begin
      cfg_err_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (cfg_bad) begin
              cfg_err_q <= 1'b1;
            end else begin
              fs_q        <= cfg_filter_size;
              nch_q       <= cfg_num_ch;
              nf_q        <= cfg_num_filters;
              base_q      <= cfg_base;
              repeat_q    <= cfg_repeat;
              stride_q    <= (ADDR_W+1)'(stride_full);
              filter_base <= cfg_base;
              addr        <= cfg_base;
              point       <= '0;
              ch          <= '0;
              filt        <= '0;
              state       <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (rd.addr_ready) begin
            addr <= mod_add(addr, (ADDR_W+1)'(1));
            if (last_point) begin
              point <= '0;
              ch    <= ch + CH_W'(1);
            end else begin
              point <= point + SIZE_W'(1);
            end
            if (fend) state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (next_filter) begin
            point <= '0;
            ch    <= '0;
            if (filt != nf_q - SIZE_W'(1)) begin
              filt        <= filt + SIZE_W'(1);
              filter_base <= mod_add(filter_base, stride_q);
              addr        <= mod_add(filter_base, stride_q);
              state       <= S_RUN;
            end else if (repeat_q) begin
              filt        <= '0;
              filter_base <= base_q;
              addr        <= base_q;
              state       <= S_RUN;
            end else begin
              state <= S_DONE;
            end
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_filter_read_addr_gen.sv
// tb_filter_read_addr_gen
// Self-checking bench for filter_read_addr_gen. Expected pointers and flags
// come from a direct arithmetic description of the filter layout:
// word i of filter f sits at (base + f*stride + i) mod depth.
module tb_filter_read_addr_gen;
  localparam int SP_DEPTH = 16;
  localparam int ADDR_W   = $clog2(SP_DEPTH);
  localparam int SIZE_W   = 8;
  localparam int CH_W     = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [SIZE_W-1:0] cfg_filter_size = '0;
  logic [CH_W-1:0]   cfg_num_ch = '0;
  logic [SIZE_W-1:0] cfg_num_filters = '0;
  logic [ADDR_W-1:0] cfg_base = '0;
  logic              cfg_repeat = 1'b0;
  logic              start = 1'b0;
  logic              next_filter = 1'b0;
  logic              busy;
  logic              done;
  logic              cfg_err;

  int total = 0;
  int bad   = 0;

  filter_read_addr_gen_if #(.ADDR_W(ADDR_W)) rd ();

  filter_read_addr_gen #(
    .SP_DEPTH(SP_DEPTH),
    .ADDR_W  (ADDR_W),
    .SIZE_W  (SIZE_W),
    .CH_W    (CH_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .cfg_filter_size(cfg_filter_size),
    .cfg_num_ch     (cfg_num_ch),
    .cfg_num_filters(cfg_num_filters),
    .cfg_base       (cfg_base),
    .cfg_repeat     (cfg_repeat),
    .start          (start),
    .next_filter    (next_filter),
    .busy           (busy),
    .done           (done),
    .cfg_err        (cfg_err),
    .rd             (rd)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit cfgValid(input int fs, input int nch, input int nf, input int base);
    return (fs > 0) && (nch > 0) && (nf > 0) && (base < SP_DEPTH) &&
           (fs * nch * nf <= SP_DEPTH);
  endfunction

  // Reset at a negedge, then check every output is cleared one cycle later.
  task automatic doReset(input string tag);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput({tag, "_valid"},  {31'd0, rd.addr_valid}, 32'd0);
    checkOutput({tag, "_ptr"},    {28'd0, rd.read_pointer}, 32'd0);
    checkOutput({tag, "_co"},     {31'd0, rd.co_filter}, 32'd0);
    checkOutput({tag, "_fend"},   {31'd0, rd.filter_end}, 32'd0);
    checkOutput({tag, "_last"},   {31'd0, rd.last_filter}, 32'd0);
    checkOutput({tag, "_busy"},   {31'd0, busy}, 32'd0);
    checkOutput({tag, "_done"},   {31'd0, done}, 32'd0);
    checkOutput({tag, "_cfgerr"}, {31'd0, cfg_err}, 32'd0);
    rst = 1'b1;
  endtask

  // One start followed by `walks` filter walks with random backpressure,
  // random ignored next_filter pulses in RUN and random WAIT gaps.
  task automatic applyStimulus(input int fs, input int nch, input int nf, input int base,
                               input bit rep, input int walks);
    int  stride;
    bit  ok;
    int  stall;
    stride = fs * nch;
    ok     = cfgValid(fs, nch, nf, base);
    @(negedge clk);
    cfg_filter_size = SIZE_W'(fs);
    cfg_num_ch      = CH_W'(nch);
    cfg_num_filters = SIZE_W'(nf);
    cfg_base        = ADDR_W'(base);
    cfg_repeat      = rep;
    start           = 1'b1;
    next_filter     = 1'b0;
    rd.addr_ready   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (!ok) begin
      checkOutput("cfg_err",      {31'd0, cfg_err}, 32'd1);
      checkOutput("err_busy",     {31'd0, busy}, 32'd0);
      checkOutput("err_valid",    {31'd0, rd.addr_valid}, 32'd0);
      @(negedge clk);
      checkOutput("cfg_err_pulse", {31'd0, cfg_err}, 32'd0);
      checkOutput("err_idle",      {31'd0, busy}, 32'd0);
      return;
    end
    checkOutput("cfg_ok", {31'd0, cfg_err}, 32'd0);
    // Configuration changes while busy must not disturb the walk.
    cfg_filter_size = SIZE_W'($urandom);
    cfg_num_ch      = CH_W'($urandom);
    cfg_num_filters = SIZE_W'($urandom);
    cfg_base        = ADDR_W'($urandom);
    cfg_repeat      = 1'($urandom);
    for (int w = 0; w < walks; w++) begin
      int f;
      int gap;
      f     = w % nf;
      stall = 0;
      for (int i = 0; i < stride; ) begin
        checkOutput("valid", {31'd0, rd.addr_valid}, 32'd1);
        checkOutput("ptr",   {28'd0, rd.read_pointer}, 32'((base + f * stride + i) % SP_DEPTH));
        checkOutput("co",    {31'd0, rd.co_filter}, 32'((i % fs) == fs - 1));
        checkOutput("fend",  {31'd0, rd.filter_end}, 32'(i == stride - 1));
        checkOutput("last",  {31'd0, rd.last_filter}, 32'(f == nf - 1));
        checkOutput("busy",  {31'd0, busy}, 32'd1);
        checkOutput("done",  {31'd0, done}, 32'd0);
        rd.addr_ready = ($urandom_range(0, 3) != 0) || (stall >= 3);
        next_filter   = ($urandom_range(0, 4) == 0);
        if (rd.addr_ready) begin
          i++;
          stall = 0;
        end else begin
          stall++;
        end
        @(negedge clk);
      end
      next_filter   = 1'b0;
      rd.addr_ready = 1'($urandom_range(0, 1));
      gap = $urandom_range(0, 2);
      for (int g = 0; g <= gap; g++) begin
        checkOutput("wait_valid", {31'd0, rd.addr_valid}, 32'd0);
        checkOutput("wait_fend",  {31'd0, rd.filter_end}, 32'd0);
        checkOutput("wait_busy",  {31'd0, busy}, 32'd1);
        checkOutput("wait_last",  {31'd0, rd.last_filter}, 32'(f == nf - 1));
        checkOutput("wait_done",  {31'd0, done}, 32'd0);
        if (g == gap) next_filter = 1'b1;
        @(negedge clk);
      end
      next_filter = 1'b0;
    end
    rd.addr_ready = 1'b1;
    if (rep) begin
      checkOutput("rep_valid", {31'd0, rd.addr_valid}, 32'd1);
      checkOutput("rep_ptr",   {28'd0, rd.read_pointer},
                  32'((base + (walks % nf) * stride) % SP_DEPTH));
      checkOutput("rep_done",  {31'd0, done}, 32'd0);
    end else begin
      checkOutput("done_pulse", {31'd0, done}, 32'd1);
      checkOutput("done_busy",  {31'd0, busy}, 32'd1);
      checkOutput("done_valid", {31'd0, rd.addr_valid}, 32'd0);
      @(negedge clk);
      checkOutput("done_clear", {31'd0, done}, 32'd0);
      checkOutput("idle_busy",  {31'd0, busy}, 32'd0);
    end
  endtask

  initial begin
    int fs;
    int nch;
    int nf;
    int base;
    rd.addr_ready = 1'b1;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_valid", {31'd0, rd.addr_valid}, 32'd0);
    checkOutput("rst_ptr",   {28'd0, rd.read_pointer}, 32'd0);
    checkOutput("rst_busy",  {31'd0, busy}, 32'd0);
    checkOutput("rst_done",  {31'd0, done}, 32'd0);
    checkOutput("rst_err",   {31'd0, cfg_err}, 32'd0);
    checkOutput("rst_last",  {31'd0, rd.last_filter}, 32'd0);
    rst = 1'b1;

    // Basic walk, wrap-around, repeat mode stopped by reset.
    applyStimulus(3, 2, 2, 0, 1'b0, 2);
    applyStimulus(2, 1, 3, 13, 1'b0, 3);
    applyStimulus(2, 1, 2, 4, 1'b1, 5);
    doReset("rep_stop");

    // Rejected configurations followed by accepted ones, incl. exact fit.
    applyStimulus(3, 2, 3, 0, 1'b0, 3);
    applyStimulus(0, 2, 1, 0, 1'b0, 1);
    applyStimulus(2, 0, 1, 3, 1'b0, 1);
    applyStimulus(1, 1, 0, 3, 1'b0, 0);
    applyStimulus(1, 1, 16, 0, 1'b0, 16);
    applyStimulus(4, 4, 1, 5, 1'b0, 1);

    // Reset during the third address of a walk.
    @(negedge clk);
    cfg_filter_size = 8'd4;
    cfg_num_ch      = 4'd2;
    cfg_num_filters = 8'd1;
    cfg_base        = 4'd7;
    cfg_repeat      = 1'b0;
    rd.addr_ready   = 1'b1;
    start           = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("mid_ptr0", {28'd0, rd.read_pointer}, 32'd7);
    @(negedge clk);
    checkOutput("mid_ptr1", {28'd0, rd.read_pointer}, 32'd8);
    @(negedge clk);
    checkOutput("mid_ptr2", {28'd0, rd.read_pointer}, 32'd9);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("mid_rst_valid", {31'd0, rd.addr_valid}, 32'd0);
    checkOutput("mid_rst_ptr",   {28'd0, rd.read_pointer}, 32'd0);
    checkOutput("mid_rst_busy",  {31'd0, busy}, 32'd0);
    checkOutput("mid_rst_done",  {31'd0, done}, 32'd0);
    rst = 1'b1;
    applyStimulus(4, 2, 1, 7, 1'b0, 1);

    // Random configurations, valid and invalid.
    for (int k = 0; k < 25; k++) begin
      fs   = $urandom_range(0, 4);
      nch  = $urandom_range(0, 3);
      nf   = $urandom_range(0, 4);
      base = $urandom_range(0, SP_DEPTH - 1);
      applyStimulus(fs, nch, nf, base, 1'b0, nf);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
